// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR sample scheduler.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } sched_state_t;

    localparam int DEF_WIDTH      = 24;
    localparam int DEF_FIFO_DEPTH = 8;
    // Occupancy needs one extra bit so a full FIFO (level == depth) is representable.
    localparam int LVL_W          = $clog2(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/fir_sched_fifo.sv
// Small synchronous FIFO buffering upstream samples for the scheduler.
module fir_sched_fifo
    import fir_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_scheduler.sv
// Issues one buffered sample per tick to the shared FIR and captures its result.
// Optional FIR_SCHED_ZERO_STUFF_EN: empty-FIFO ticks issue a zero sample instead of skipping.
module fir_sample_scheduler
    import fir_sched_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int FIR_LATENCY = 4,
    parameter int DIV_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [DIV_W-1:0]             period,
    input  logic [WIDTH-1:0]             in_sig,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             fir_sig,
    output logic                         fir_ready,
    input  logic [WIDTH-1:0]             fir_some,
    output logic [WIDTH-1:0]             out_sig,
    output logic                         out_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun,
    output logic                         late
);
    localparam int WCW = (FIR_LATENCY > 2) ? $clog2(FIR_LATENCY - 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((FIR_LATENCY >= 2) ? FIR_LATENCY - 2 : 0);

    sched_state_t     state;
    logic [WCW-1:0]   wcnt;
    logic [DIV_W-1:0] div_cnt;
    logic             pending;
    logic             tick, take, push, pop, full, empty;
    logic [WIDTH-1:0] head;

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign tick     = enable && (div_cnt == period);
    // A pending tick is consumed in IDLE whether it issues or underruns.
    assign take     = (state == IDLE) && pending;
    assign pop      = take && !empty;

    fir_sched_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_sig),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pending <= 1'b0;
            late    <= 1'b0;
        end else begin
            if (!enable || div_cnt == period) div_cnt <= '0;
            else                              div_cnt <= div_cnt + 1'b1;
            if (tick)      pending <= 1'b1;
            else if (take) pending <= 1'b0;
            if (tick && pending && !take) late <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= '0;
            fir_sig   <= '0;
            fir_ready <= 1'b0;
            out_sig   <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            fir_ready <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        if (!empty) begin
                            state     <= ISSUE;
                            fir_sig   <= head;
                            fir_ready <= 1'b1;
                        end else begin
                            underrun  <= 1'b1;
`ifdef FIR_SCHED_ZERO_STUFF_EN
                            state     <= ISSUE;
                            fir_sig   <= '0;
                            fir_ready <= 1'b1;
`endif
                        end
                    end
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= (FIR_LATENCY == 1) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    if (wcnt == WAIT_LAST) state <= CAPTURE;
                    else                   wcnt  <= wcnt + 1'b1;
                end
                CAPTURE: begin
                    out_sig   <= fir_some;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
